led_matrix_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 5x7 irrigation-status LED matrix. It captures a full frame image from the per-column status decoders, then drives one column at a time for a programmable dwell period. Each column period is preceded by a blanking gap to suppress ghosting. It sits between the column decoder bank and the matrix pins, and is the only sequential block on the display path.

---
 rtl/led_matrix_scan_controller.sv | 123 ++++++++++++
 tb/tb_led_matrix_scan_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_controller.sv
// rtl/led_matrix_scan_controller.sv - time-multiplexed column scan for the status LED matrix
// Captures a frame into a shadow register, then blanks and drives each column in turn.
module led_matrix_scan_controller #(
  parameter int NUM_COLS     = 5,
  parameter int NUM_ROWS     = 7,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_COLS*NUM_ROWS-1:0] image_in,
  output logic [NUM_COLS-1:0]          columns,
  output logic [NUM_ROWS-1:0]          rows,
  output logic [2:0]                   col_index,
  output logic                         frame_start
);

  localparam int IW      = NUM_COLS * NUM_ROWS;
  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [2:0]    LAST_COL   = 3'(NUM_COLS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [IW-1:0]       r_shadow, w_shadow_nxt;
  logic [2:0]          r_col, w_col_nxt;
  logic [NUM_COLS-1:0] r_columns, w_columns_nxt;
  logic [NUM_ROWS-1:0] r_rows, w_rows_nxt;
  logic                r_frame_start, w_frame_start_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_shadow      <= '0;
      r_col         <= '0;
      r_columns     <= '1;
      r_rows        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_shadow      <= w_shadow_nxt;
      r_col         <= w_col_nxt;
      r_columns     <= w_columns_nxt;
      r_rows        <= w_rows_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  // Outputs default to dark; only the DRIVE hold path keeps the lit column.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_shadow_nxt      = r_shadow;
    w_col_nxt         = r_col;
    w_columns_nxt     = '1;
    w_rows_nxt        = '0;
    w_frame_start_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_col_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_shadow_nxt      = image_in;
          w_col_nxt         = '0;
          w_cnt_nxt         = '0;
          w_state_nxt       = ST_BLANK;
          w_frame_start_nxt = 1'b1;
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt   = ST_DRIVE;
            w_cnt_nxt     = '0;
            w_columns_nxt = ~(NUM_COLS'(1) << r_col);
            w_rows_nxt    = r_shadow[r_col*NUM_ROWS +: NUM_ROWS];
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == DWELL_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            if (r_col == LAST_COL) begin
              w_col_nxt         = '0;
              w_shadow_nxt      = image_in;
              w_frame_start_nxt = 1'b1;
            end else begin
              w_col_nxt = r_col + 3'd1;
            end
          end else begin
            w_cnt_nxt     = r_cnt + 1'b1;
            w_columns_nxt = r_columns;
            w_rows_nxt    = r_rows;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign columns     = r_columns;
  assign rows        = r_rows;
  assign col_index   = r_col;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_led_matrix_scan_controller.sv
// tb/tb_led_matrix_scan_controller.sv - directed and randomised checks of the LED scan controller
module tb_led_matrix_scan_controller;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [34:0] image_in;
  logic [4:0]  columns;
  logic [6:0]  rows;
  logic [2:0]  col_index;
  logic        frame_start;

  int n_checks = 0;
  int n_pass   = 0;

  led_matrix_scan_controller #(
    .NUM_COLS    (5),
    .NUM_ROWS    (7),
    .DWELL_CYCLES(3),
    .BLANK_CYCLES(2)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .image_in   (image_in),
    .columns    (columns),
    .rows       (rows),
    .col_index  (col_index),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Entered one cycle after a capture edge; walks all five columns and the capture at the end.
  task automatic run_frame(input logic [34:0] exp_img, input int chg_col, input logic [34:0] new_img);
    logic [4:0] e_cols;
    logic [6:0] e_rows;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("blank_cols", 32'(columns), 32'h1f);
      check("blank_rows", 32'(rows), 32'h0);
      e_cols = 5'h1f ^ (5'd1 << c);
      e_rows = exp_img[c*7 +: 7];
      for (int d = 0; d < 3; d++) begin
        tick();
        check("drv_cols", 32'(columns), 32'(e_cols));
        check("drv_rows", 32'(rows), 32'(e_rows));
        check("drv_idx", 32'(col_index), 32'(c));
        check("drv_fs", 32'(frame_start), 32'h0);
        if (c == chg_col && d == 0) image_in = new_img;
      end
      tick();
      check("gap_cols", 32'(columns), 32'h1f);
      check("gap_rows", 32'(rows), 32'h0);
      check("gap_idx", 32'(col_index), 32'((c + 1) % 5));
      check("gap_fs", 32'(frame_start), (c == 4) ? 32'h1 : 32'h0);
    end
  endtask

  logic [34:0] img_a;
  logic [34:0] img_b;
  logic [63:0] rnd;

  initial begin
    img_a    = {7'h4C, 7'h33, 7'h70, 7'h0F, 7'h55};
    img_b    = {7'h4C, 7'h11, 7'h70, 7'h0F, 7'h55};
    rst_n    = 1'b1;
    enable   = 1'b0;
    image_in = img_a;
    #2 rst_n = 1'b0;
    #2;
    check("rst_cols", 32'(columns), 32'h1f);
    check("rst_rows", 32'(rows), 32'h0);
    check("rst_idx", 32'(col_index), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    tick_n(2);
    check("rst_hold_cols", 32'(columns), 32'h1f);
    rst_n = 1'b1;
    tick();
    check("idle_cols", 32'(columns), 32'h1f);
    check("idle_fs", 32'(frame_start), 32'h0);

    enable = 1'b1;
    tick();
    check("start_fs", 32'(frame_start), 32'h1);
    check("start_cols", 32'(columns), 32'h1f);
    check("start_idx", 32'(col_index), 32'h0);
    check("start_rows", 32'(rows), 32'h0);
    run_frame(img_a, -1, '0);
    run_frame(img_a, 1, img_b);
    run_frame(img_b, -1, '0);

    tick_n(12);
    check("pre_dis_cols", 32'(columns), 32'h1b);
    check("pre_dis_idx", 32'(col_index), 32'h2);
    enable = 1'b0;
    tick();
    check("dis_cols", 32'(columns), 32'h1f);
    check("dis_rows", 32'(rows), 32'h0);
    check("dis_idx", 32'(col_index), 32'h0);
    check("dis_fs", 32'(frame_start), 32'h0);
    tick();
    check("dis_hold_cols", 32'(columns), 32'h1f);
    check("dis_hold_fs", 32'(frame_start), 32'h0);
    enable = 1'b1;
    tick();
    check("reen_fs", 32'(frame_start), 32'h1);
    check("reen_cols0", 32'(columns), 32'h1f);
    tick();
    check("reen_fs_low", 32'(frame_start), 32'h0);
    check("reen_cols1", 32'(columns), 32'h1f);
    tick();
    check("reen_drv_cols", 32'(columns), 32'h1e);
    check("reen_drv_rows", 32'(rows), 32'h55);
    check("reen_drv_idx", 32'(col_index), 32'h0);

    #3 rst_n = 1'b0;
    #1;
    check("arst_cols", 32'(columns), 32'h1f);
    check("arst_rows", 32'(rows), 32'h0);
    check("arst_idx", 32'(col_index), 32'h0);
    check("arst_fs", 32'(frame_start), 32'h0);
    tick_n(2);
    check("arst_hold_cols", 32'(columns), 32'h1f);
    check("arst_hold_rows", 32'(rows), 32'h0);
    enable = 1'b0;
    rst_n  = 1'b1;
    tick();

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) enable = ~enable;
      rnd      = {$urandom(), $urandom()};
      image_in = rnd[34:0];
      tick();
      check("inv_onehot", ($countones(~columns) <= 1) ? 32'h1 : 32'h0, 32'h1);
      if (columns == 5'h1f) check("inv_dark_rows", 32'(rows), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
